multicycle_control: RTL and testbench
=====================================

# multicycle_control

Moore-style sequencer for the multicycle MIPS datapath: one instruction executes over 3–5 states, sharing a single ALU and a unified instruction/data memory. Takes the opcode from the instruction register and the ALU Zero flag, and drives every mux select and write enable of the datapath. Replaces the per-instruction combinational control used in the single-cycle core.

## Interface
Parameters: none.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- Op  in  6  opcode, IR[31:26], valid from DECODE onward
- Zero  in  1  ALU zero flag
- MemReady  in  1  memory access complete; used only with MCCTRL_MEMWAIT_EN
- PCEn  out  1  PC write enable = PCWrite | (Branch & Zero)
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- MemWrite  out  1  data memory write
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register: 0 = rt, 1 = rd
- MemtoReg  out  1  writeback data: 0 = ALUOut, 1 = Data
- RegWrite  out  1  register file write
- ALUSrcA  out  1  0 = PC, 1 = A
- ALUSrcB  out  2  00 = B, 01 = 4, 10 = SignImm, 11 = SignImm<<2
- PCSrc  out  2  00 = ALUResult, 01 = ALUOut, 10 = jump target
- ALUOp  out  2  00 add, 01 sub, 10 decode Funct (same encoding as the ALU decoder)
- State  out  4  current state, for debug
- IllegalOp  out  1  sticky: unsupported opcode decoded

## Operation
States and transitions:
- FETCH: IorD=0, IRWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, PCWrite=1 → DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target). Branches on Op: 100011/101011 → MEMADR; 000000 → EXECUTE; 000100 → BEQ; 001000 → ADDIEX; 000010 → JUMP; others → FETCH and set IllegalOp.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw → MEMRD; sw → MEMWR.
- MEMRD: IorD=1 → MEMWB. MEMWB: RegDst=0, MemtoReg=1, RegWrite=1 → FETCH.
- MEMWR: IorD=1, MemWrite=1 → FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10 → ALUWB. ALUWB: RegDst=1, MemtoReg=0, RegWrite=1 → FETCH.
- BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1 → FETCH.
- ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=00 → ADDIWB. ADDIWB: RegDst=0, MemtoReg=0, RegWrite=1 → FETCH.
- JUMP: PCSrc=10, PCWrite=1 → FETCH.
- Every signal not listed for a state is 0. Unused state encodings → FETCH next cycle, all outputs 0.
- Outputs are decoded combinationally from the state register only, except PCEn, which also uses Zero, and the MemReady gating below.

## Timing
- Reset: State=FETCH, IllegalOp=0. While reset_n=0, PCEn, IRWrite, MemWrite and RegWrite are forced to 0, independent of clk. Mux selects show FETCH values.
- Reset mid-instruction aborts it. The first edge after release performs FETCH.
- Cycles per instruction without wait: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
- IllegalOp is set on the DECODE→FETCH edge and held until reset. Costs 2 cycles; no register or memory write.
- Branch taken iff Zero=1 during BEQ. PCEn is combinational in that cycle.

## Configuration
- MCCTRL_MEMWAIT_EN defined: FETCH, MEMRD and MEMWR hold while MemReady=0.
  - In FETCH, IRWrite and PCWrite are asserted only in a cycle with MemReady=1.
  - In MEMWR, MemWrite is held high throughout the wait.
  - The state advances on the edge where MemReady=1.
- MCCTRL_MEMWAIT_EN not defined: MemReady is ignored and every memory state takes exactly 1 cycle.

## Structure
- Shared package/header mips_defs: opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), ALUOp encodings, state encodings (4-bit localparams), ALUSrcB/PCSrc encodings.
- Sub-module mc_output_decode: State → control word, purely combinational. The top holds the state register, next-state logic, IllegalOp, MemReady gating and PCEn.

## Test plan
- Reset asserted mid-MEMRD, then released → State=FETCH, write enables 0 during reset, FETCH values on the next cycle.
- Op=100011 (lw), MemReady=1 → state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB; RegWrite=1 and MemtoReg=1 only in MEMWB; 5 cycles.
- Op=000100 with Zero=1, then again with Zero=0 → PCEn=1 in BEQ in the first case, 0 in the second; ALUOp=01 both times.
- Op=000000 then Op=001000 → EXECUTE (ALUOp=10) then ALUWB with RegDst=1; ADDIEX then ADDIWB with RegDst=0; 4 cycles each.
- Op=111111 → DECODE→FETCH, IllegalOp=1 and still 1 after a following valid j (3 cycles, PCSrc=10).
- With MCCTRL_MEMWAIT_EN: sw with MemReady low for 3 cycles in MEMWR → MemWrite=1 for 4 cycles, FETCH on the MemReady=1 edge. FETCH with MemReady=0 → IRWrite=0, PCEn=0.

Source files
------------

// File: rtl/mips_defs.sv
// Shared definitions for the multicycle MIPS control path: opcodes, ALU
// operation encodings, mux select encodings, sequencer state encodings and
// the control word produced by the output decoder.
package mips_defs;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_FUNCT = 2'b10;

   localparam logic [1:0] SRCB_B     = 2'b00;
   localparam logic [1:0] SRCB_FOUR  = 2'b01;
   localparam logic [1:0] SRCB_IMM   = 2'b10;
   localparam logic [1:0] SRCB_IMMSH = 2'b11;

   localparam logic [1:0] PCSRC_ALURESULT = 2'b00;
   localparam logic [1:0] PCSRC_ALUOUT    = 2'b01;
   localparam logic [1:0] PCSRC_JUMP      = 2'b10;

   localparam logic [3:0] S_FETCH   = 4'd0;
   localparam logic [3:0] S_DECODE  = 4'd1;
   localparam logic [3:0] S_MEMADR  = 4'd2;
   localparam logic [3:0] S_MEMRD   = 4'd3;
   localparam logic [3:0] S_MEMWB   = 4'd4;
   localparam logic [3:0] S_MEMWR   = 4'd5;
   localparam logic [3:0] S_EXECUTE = 4'd6;
   localparam logic [3:0] S_ALUWB   = 4'd7;
   localparam logic [3:0] S_BEQ     = 4'd8;
   localparam logic [3:0] S_ADDIEX  = 4'd9;
   localparam logic [3:0] S_ADDIWB  = 4'd10;
   localparam logic [3:0] S_JUMP    = 4'd11;

   typedef enum logic [3:0] {
      ST_FETCH   = S_FETCH,
      ST_DECODE  = S_DECODE,
      ST_MEMADR  = S_MEMADR,
      ST_MEMRD   = S_MEMRD,
      ST_MEMWB   = S_MEMWB,
      ST_MEMWR   = S_MEMWR,
      ST_EXECUTE = S_EXECUTE,
      ST_ALUWB   = S_ALUWB,
      ST_BEQ     = S_BEQ,
      ST_ADDIEX  = S_ADDIEX,
      ST_ADDIWB  = S_ADDIWB,
      ST_JUMP    = S_JUMP
   } state_t;

   // Raw per-state control word; PCWrite/Branch are combined into PCEn by the top.
   typedef struct packed {
      logic       pcWrite;
      logic       branch;
      logic       iorD;
      logic       memWrite;
      logic       irWrite;
      logic       regDst;
      logic       memtoReg;
      logic       regWrite;
      logic       aluSrcA;
      logic [1:0] aluSrcB;
      logic [1:0] pcSrc;
      logic [1:0] aluOp;
   } ctrl_t;

   // True for the opcodes this sequencer knows how to execute.
   function automatic logic isLegalOp(input logic [5:0] op);
      return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
             (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
   endfunction

endpackage

// File: rtl/mc_output_decode.sv
// Moore output decoder: maps the sequencer state to the raw datapath control
// word. Unused state encodings produce an all-zero word.
module mc_output_decode
   import mips_defs::*;
(
   input  logic [3:0] i_state,
   output ctrl_t      o_ctrl
);

   // Per-state control word, everything not named for a state stays 0
   always_comb begin
      o_ctrl = '0;
      case (i_state)
         S_FETCH: begin
            o_ctrl.irWrite = 1'b1;
            o_ctrl.aluSrcB = SRCB_FOUR;
            o_ctrl.aluOp   = ALUOP_ADD;
            o_ctrl.pcSrc   = PCSRC_ALURESULT;
            o_ctrl.pcWrite = 1'b1;
         end
         S_DECODE: begin
            o_ctrl.aluSrcB = SRCB_IMMSH;
            o_ctrl.aluOp   = ALUOP_ADD;
         end
         S_MEMADR: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_IMM;
            o_ctrl.aluOp   = ALUOP_ADD;
         end
         S_MEMRD: begin
            o_ctrl.iorD = 1'b1;
         end
         S_MEMWB: begin
            o_ctrl.memtoReg = 1'b1;
            o_ctrl.regWrite = 1'b1;
         end
         S_MEMWR: begin
            o_ctrl.iorD     = 1'b1;
            o_ctrl.memWrite = 1'b1;
         end
         S_EXECUTE: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_B;
            o_ctrl.aluOp   = ALUOP_FUNCT;
         end
         S_ALUWB: begin
            o_ctrl.regDst   = 1'b1;
            o_ctrl.regWrite = 1'b1;
         end
         S_BEQ: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_B;
            o_ctrl.aluOp   = ALUOP_SUB;
            o_ctrl.pcSrc   = PCSRC_ALUOUT;
            o_ctrl.branch  = 1'b1;
         end
         S_ADDIEX: begin
            o_ctrl.aluSrcA = 1'b1;
            o_ctrl.aluSrcB = SRCB_IMM;
            o_ctrl.aluOp   = ALUOP_ADD;
         end
         S_ADDIWB: begin
            o_ctrl.regWrite = 1'b1;
         end
         S_JUMP: begin
            o_ctrl.pcSrc   = PCSRC_JUMP;
            o_ctrl.pcWrite = 1'b1;
         end
         default: o_ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle MIPS control sequencer. Holds the state register, next-state
// logic, the sticky IllegalOp flag, memory-ready gating and PCEn.
// Optional feature: define MCCTRL_MEMWAIT_EN to stall FETCH, MEMRD and MEMWR
// until MemReady is high; otherwise MemReady is ignored.
module multicycle_control
   import mips_defs::*;
(
   input  logic       clk,
   input  logic       reset_n,
   input  logic [5:0] Op,
   input  logic       Zero,
   input  logic       MemReady,
   output logic       PCEn,
   output logic       IorD,
   output logic       MemWrite,
   output logic       IRWrite,
   output logic       RegDst,
   output logic       MemtoReg,
   output logic       RegWrite,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [1:0] PCSrc,
   output logic [1:0] ALUOp,
   output logic [3:0] State,
   output logic       IllegalOp
);

   state_t r_state;
   state_t w_nextState;
   ctrl_t  w_ctrl;
   logic   r_illegalOp;
   logic   w_memReady;
   logic   w_memState;
   logic   w_fetchGate;

`ifdef MCCTRL_MEMWAIT_EN
   assign w_memReady = MemReady;
`else
   logic w_unusedMemReady;
   assign w_unusedMemReady = MemReady;
   assign w_memReady       = 1'b1;
`endif

   mc_output_decode u_outputDecode (
      .i_state (r_state),
      .o_ctrl  (w_ctrl)
   );

   assign w_memState  = (r_state == ST_FETCH) || (r_state == ST_MEMRD) || (r_state == ST_MEMWR);
   assign w_fetchGate = (r_state == ST_FETCH) ? w_memReady : 1'b1;

   // State register; reset aborts any instruction and returns to FETCH
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) r_state <= ST_FETCH;
      else          r_state <= w_nextState;
   end

   // Next-state logic, memory states hold while the memory is not ready
   always_comb begin
      w_nextState = ST_FETCH;
      case (r_state)
         ST_FETCH:   w_nextState = ST_DECODE;
         ST_DECODE: begin
            case (Op)
               OP_LW, OP_SW: w_nextState = ST_MEMADR;
               OP_RTYPE:     w_nextState = ST_EXECUTE;
               OP_BEQ:       w_nextState = ST_BEQ;
               OP_ADDI:      w_nextState = ST_ADDIEX;
               OP_J:         w_nextState = ST_JUMP;
               default:      w_nextState = ST_FETCH;
            endcase
         end
         ST_MEMADR:  w_nextState = (Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
         ST_MEMRD:   w_nextState = ST_MEMWB;
         ST_EXECUTE: w_nextState = ST_ALUWB;
         ST_ADDIEX:  w_nextState = ST_ADDIWB;
         default:    w_nextState = ST_FETCH;
      endcase
      if (w_memState && !w_memReady) w_nextState = r_state;
   end

   // Sticky illegal-opcode flag, set when DECODE sees an unsupported opcode
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)                                     r_illegalOp <= 1'b0;
      else if ((r_state == ST_DECODE) && !isLegalOp(Op)) r_illegalOp <= 1'b1;
   end

   // Output drive; write enables are forced low while reset is asserted
   always_comb begin
      PCEn      = reset_n & ((w_ctrl.pcWrite & w_fetchGate) | (w_ctrl.branch & Zero));
      IRWrite   = reset_n & w_ctrl.irWrite & w_fetchGate;
      MemWrite  = reset_n & w_ctrl.memWrite;
      RegWrite  = reset_n & w_ctrl.regWrite;
      IorD      = w_ctrl.iorD;
      RegDst    = w_ctrl.regDst;
      MemtoReg  = w_ctrl.memtoReg;
      ALUSrcA   = w_ctrl.aluSrcA;
      ALUSrcB   = w_ctrl.aluSrcB;
      PCSrc     = w_ctrl.pcSrc;
      ALUOp     = w_ctrl.aluOp;
      State     = r_state;
      IllegalOp = r_illegalOp;
   end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed instructions, a
// randomized instruction stream and a mid-instruction reset, all compared
// cycle by cycle against an instruction-level reference model.
// Honours MCCTRL_MEMWAIT_EN when the design is built with it.
module tb_multicycle_control;
   import mips_defs::*;

`ifdef MCCTRL_MEMWAIT_EN
   localparam bit memWaitEn = 1'b1;
`else
   localparam bit memWaitEn = 1'b0;
`endif

   typedef int intQ[$];

   logic       clk = 1'b0;
   logic       reset_n;
   logic [5:0] Op;
   logic       Zero;
   logic       MemReady;
   logic       PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
   logic [1:0] ALUSrcB, PCSrc, ALUOp;
   logic [3:0] State;
   logic       IllegalOp;

   int   checkCount   = 0;
   int   passCount    = 0;
   logic modelIllegal = 1'b0;

   multicycle_control dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .Op        (Op),
      .Zero      (Zero),
      .MemReady  (MemReady),
      .PCEn      (PCEn),
      .IorD      (IorD),
      .MemWrite  (MemWrite),
      .IRWrite   (IRWrite),
      .RegDst    (RegDst),
      .MemtoReg  (MemtoReg),
      .RegWrite  (RegWrite),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .PCSrc     (PCSrc),
      .ALUOp     (ALUOp),
      .State     (State),
      .IllegalOp (IllegalOp)
   );

   // Free-running 10-time-unit clock
   always #5 clk = ~clk;

   // Watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed === expected) passCount++;
      else $display("[TB] FAIL %s at %0t: got %0h, expected %0h", tag, $time, observed, expected);
   endtask

   // State walk of one instruction as listed by the instruction timing table
   function automatic intQ buildSeq(input logic [5:0] op);
      intQ q;
      q = '{32'(S_FETCH), 32'(S_DECODE)};
      case (op)
         OP_LW:    begin q.push_back(32'(S_MEMADR)); q.push_back(32'(S_MEMRD)); q.push_back(32'(S_MEMWB)); end
         OP_SW:    begin q.push_back(32'(S_MEMADR)); q.push_back(32'(S_MEMWR)); end
         OP_RTYPE: begin q.push_back(32'(S_EXECUTE)); q.push_back(32'(S_ALUWB)); end
         OP_ADDI:  begin q.push_back(32'(S_ADDIEX)); q.push_back(32'(S_ADDIWB)); end
         OP_BEQ:   q.push_back(32'(S_BEQ));
         OP_J:     q.push_back(32'(S_JUMP));
         default:  ;
      endcase
      return q;
   endfunction

   // Expected {PCEn,IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,ALUSrcB,PCSrc,ALUOp}
   function automatic logic [13:0] expectedCtrl(input int st, input logic zero, input logic rdy);
      logic pcEn, iorD, memWr, irWr, regDst, memtoReg, regWr, srcA, fetchOk;
      logic [1:0] srcB, pcSrc, aluOp;
      {pcEn, iorD, memWr, irWr, regDst, memtoReg, regWr, srcA} = 8'b0;
      srcB    = 2'b00;
      pcSrc   = 2'b00;
      aluOp   = 2'b00;
      fetchOk = memWaitEn ? rdy : 1'b1;
      case (st)
         32'(S_FETCH):   begin irWr = fetchOk; pcEn = fetchOk; srcB = 2'b01; end
         32'(S_DECODE):  srcB = 2'b11;
         32'(S_MEMADR):  begin srcA = 1'b1; srcB = 2'b10; end
         32'(S_MEMRD):   iorD = 1'b1;
         32'(S_MEMWB):   begin memtoReg = 1'b1; regWr = 1'b1; end
         32'(S_MEMWR):   begin iorD = 1'b1; memWr = 1'b1; end
         32'(S_EXECUTE): begin srcA = 1'b1; aluOp = 2'b10; end
         32'(S_ALUWB):   begin regDst = 1'b1; regWr = 1'b1; end
         32'(S_BEQ):     begin srcA = 1'b1; aluOp = 2'b01; pcSrc = 2'b01; pcEn = zero; end
         32'(S_ADDIEX):  begin srcA = 1'b1; srcB = 2'b10; end
         32'(S_ADDIWB):  regWr = 1'b1;
         32'(S_JUMP):    begin pcSrc = 2'b10; pcEn = 1'b1; end
         default:        ;
      endcase
      return {pcEn, iorD, memWr, irWr, regDst, memtoReg, regWr, srcA, srcB, pcSrc, aluOp};
   endfunction

   function automatic logic isKnownOp(input logic [5:0] op);
      return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
             (op == 6'b000100) || (op == 6'b001000) || (op == 6'b000010);
   endfunction

   function automatic logic [5:0] randomOp();
      logic [5:0] ops [6];
      logic [5:0] op;
      ops = '{OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J};
      if ($urandom_range(0, 6) < 6) return ops[$urandom_range(0, 5)];
      op = 6'($urandom);
      while (isKnownOp(op)) op = 6'($urandom);
      return op;
   endfunction

   // Runs one instruction starting at its FETCH cycle and checks every cycle.
   // zeroMode: 0/1 forces Zero, -1 randomizes. lowCycles: MemReady low for that
   // many cycles of each memory-state visit, -1 randomizes.
   task automatic applyStimulus(input logic [5:0] op, input int zeroMode, input int lowCycles);
      intQ  seq;
      int   st;
      int   waited;
      logic rdy;
      logic isMem;
      seq    = buildSeq(op);
      waited = 0;
      while (seq.size() > 0) begin
         st = seq[0];
         @(negedge clk);
         Op    = (st == 32'(S_FETCH)) ? 6'($urandom) : op;
         Zero  = (zeroMode < 0) ? 1'($urandom) : 1'(zeroMode);
         isMem = (st == 32'(S_FETCH)) || (st == 32'(S_MEMRD)) || (st == 32'(S_MEMWR));
         if (!isMem)            rdy = 1'($urandom);
         else if (lowCycles < 0) rdy = ($urandom_range(0, 3) != 0) || (waited >= 6);
         else                    rdy = (waited >= lowCycles);
         MemReady = rdy;
         #1;
         checkOutput("state", 32'(State), 32'(st));
         checkOutput($sformatf("ctrl_s%0d", st),
                     32'({PCEn, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, PCSrc, ALUOp}),
                     32'(expectedCtrl(st, Zero, rdy)));
         checkOutput("illegalOp", 32'(IllegalOp), 32'(modelIllegal));
         if (memWaitEn && isMem && !rdy) begin
            waited++;
         end else begin
            void'(seq.pop_front());
            waited = 0;
            if ((st == 32'(S_DECODE)) && !isKnownOp(op)) modelIllegal = 1'b1;
         end
      end
   endtask

   // Reset-time view: FETCH state, no writes, FETCH mux selects, flag clear
   task automatic checkReset(input string tag);
      checkOutput({tag, "_state"}, 32'(State), 32'(S_FETCH));
      checkOutput({tag, "_wrEn"}, 32'({PCEn, IRWrite, MemWrite, RegWrite}), 32'h0);
      checkOutput({tag, "_sel"}, 32'({IorD, ALUSrcA, ALUSrcB, PCSrc, ALUOp, RegDst, MemtoReg}), 32'b0_0_01_00_00_0_0);
      checkOutput({tag, "_illegal"}, 32'(IllegalOp), 32'h0);
   endtask

   // Walks lw into MEMRD, then asserts reset asynchronously and releases it
   task automatic resetMidMemrd();
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         Op       = OP_LW;
         Zero     = 1'($urandom);
         MemReady = 1'b1;
      end
      @(negedge clk);
      #1;
      checkOutput("preResetState", 32'(State), 32'(S_MEMRD));
      reset_n      = 1'b0;
      modelIllegal = 1'b0;
      #1;
      checkReset("midReset");
      @(posedge clk);
      @(negedge clk);
      #1;
      checkReset("heldReset");
      @(posedge clk);
      #2 reset_n = 1'b1;
   endtask

   // Main sequence
   initial begin
      reset_n  = 1'b0;
      Op       = 6'b0;
      Zero     = 1'b0;
      MemReady = 1'b1;
      #1;
      checkReset("initReset");
      @(posedge clk);
      #2 reset_n = 1'b1;

      $display("[TB] directed instructions");
      applyStimulus(OP_LW, -1, 0);
      applyStimulus(OP_SW, -1, 0);
      applyStimulus(OP_RTYPE, -1, 0);
      applyStimulus(OP_ADDI, -1, 0);
      applyStimulus(OP_BEQ, 1, 0);
      applyStimulus(OP_BEQ, 0, 0);
      applyStimulus(6'b111111, -1, 0);
      applyStimulus(OP_J, -1, 0);
      applyStimulus(OP_SW, -1, 3);
      applyStimulus(OP_LW, -1, 2);

      $display("[TB] random instruction stream");
      for (int i = 0; i < 120; i++) applyStimulus(randomOp(), -1, -1);

      $display("[TB] reset during MEMRD");
      applyStimulus(6'b110000, -1, 0);
      resetMidMemrd();
      for (int i = 0; i < 30; i++) applyStimulus(randomOp(), -1, -1);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule
